dht11_sensor_emulator: RTL and testbench

DHT11_SENSOR_EMULATOR -- requirements
Module: dht11_sensor_emulator

---
 rtl/dht11_sensor_emulator.sv | 107 ++++++++++
 tb/tb_dht11_sensor_emulator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emulator.sv
// dht11_sensor_emulator: DHT11 single-wire sensor model answering host start requests with a 40-bit frame
module dht11_sensor_emulator #(
  parameter int MIN_START_LOW = 18000,
  parameter int TURN          = 30,
  parameter int RESP_LOW      = 80,
  parameter int RESP_HIGH     = 80,
  parameter int BIT_LOW       = 50,
  parameter int ZERO_HIGH     = 26,
  parameter int ONE_HIGH      = 70,
  parameter int END_LOW       = 50
) (
  input  logic       clock,
  input  logic       rst_n,
  inout  wire        dat_io,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       inject_error,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_TURN_WAIT, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_END_LOW, S_DONE
  } state_t;
  // The host release reaches the FSM three cycles late (two sync flops plus
  // the START_LOW exit), so TURN_WAIT is shortened to keep TURN exact on the wire.
  localparam int SYNC_LAT = 3;
  localparam logic [15:0] TURN_LAST      = 16'(TURN - SYNC_LAT - 1);
  localparam logic [15:0] RESP_LOW_LAST  = 16'(RESP_LOW - 1);
  localparam logic [15:0] RESP_HIGH_LAST = 16'(RESP_HIGH - 1);
  localparam logic [15:0] BIT_LOW_LAST   = 16'(BIT_LOW - 1);
  localparam logic [15:0] ZERO_LAST      = 16'(ZERO_HIGH - 1);
  localparam logic [15:0] ONE_LAST       = 16'(ONE_HIGH - 1);
  localparam logic [15:0] END_LOW_LAST   = 16'(END_LOW - 1);
  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d, phase_last;
  logic [5:0]  bit_q, bit_d;
  logic [39:0] frame_q;
  logic [7:0]  sum;
  logic        line_s, load, long_low, phase_end, cur_bit, drive_low;
  assign line_s    = sync_q[1];
  assign sum       = hum_int + hum_dec + tmp_int + tmp_dec;
  assign cur_bit   = frame_q[6'd39 - bit_q];
  assign long_low  = cnt_q >= 16'(MIN_START_LOW);
  assign phase_last = state_q == S_TURN_WAIT ? TURN_LAST :
                      state_q == S_RESP_LOW  ? RESP_LOW_LAST :
                      state_q == S_RESP_HIGH ? RESP_HIGH_LAST :
                      state_q == S_BIT_LOW   ? BIT_LOW_LAST :
                      state_q == S_BIT_HIGH  ? (cur_bit ? ONE_LAST : ZERO_LAST) :
                      state_q == S_END_LOW   ? END_LOW_LAST : 16'd0;
  assign phase_end  = cnt_q == phase_last;
  assign drive_low  = state_q inside {S_RESP_LOW, S_BIT_LOW, S_END_LOW};
  assign dat_io     = drive_low ? 1'b0 : 1'bz;
  assign busy       = !(state_q inside {S_IDLE, S_START_LOW});
  assign frame_done = state_q == S_DONE;
  // State, phase counter, bit index, frame snapshot and line synchronizer
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sync_q  <= {sync_q[0], dat_io};
      frame_q <= load ? {hum_int, hum_dec, tmp_int, tmp_dec, inject_error ? ~sum : sum} : frame_q;
    end
  end
  // Next state: start detection from IDLE, then fixed-length phases driven by the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = line_s ? 16'd0 : 16'd1;
        state_d = line_s ? S_IDLE : S_START_LOW;
      end
      S_START_LOW: begin
        load    = line_s && long_low;
        cnt_d   = line_s ? 16'd0 : (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1);
        state_d = line_s ? (long_low ? S_TURN_WAIT : S_IDLE) : S_START_LOW;
      end
      S_TURN_WAIT: state_d = phase_end ? S_RESP_LOW : state_q;
      S_RESP_LOW:  state_d = phase_end ? S_RESP_HIGH : state_q;
      S_RESP_HIGH: begin
        state_d = phase_end ? S_BIT_LOW : state_q;
        bit_d   = phase_end ? 6'd0 : bit_q;
      end
      S_BIT_LOW:   state_d = phase_end ? S_BIT_HIGH : state_q;
      S_BIT_HIGH: begin
        state_d = !phase_end ? state_q : (bit_q == 6'd39 ? S_END_LOW : S_BIT_LOW);
        bit_d   = (phase_end && bit_q != 6'd39) ? bit_q + 6'd1 : bit_q;
      end
      S_END_LOW:   state_d = phase_end ? S_DONE : state_q;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// tb_dht11_sensor_emulator: host-side bench measuring every bus phase against a frame model
`timescale 1ns/1ps
module tb_dht11_sensor_emulator;
  // Start threshold is shortened to keep runs brief; every other timing stays at its default.
  localparam int MIN = 2000;
  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, tmp_int = '0, tmp_dec = '0;
  logic       inject_error = 1'b0;
  logic       busy, frame_done;
  logic       cur;
  wire        dat;
  int         total = 0, bad = 0, fd_cnt = 0;

  assign dat = host_low ? 1'b0 : 1'bz;
  pullup (dat);

  always #500 clock = ~clock;
  always @(negedge clock) if (frame_done === 1'b1) fd_cnt++;

  dht11_sensor_emulator #(.MIN_START_LOW(MIN)) dut (
    .clock(clock), .rst_n(rst_n), .dat_io(dat),
    .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .inject_error(inject_error), .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Length of the run of equal negedge samples starting with cur; leaves the next run's first sample in cur.
  task automatic get_run(output int len);
    logic s;
    len = 1;
    while (1) begin
      @(negedge clock);
      s = dat;
      if (s !== cur || len >= 400) begin
        cur = s;
        break;
      end
      len++;
    end
  endtask

  task automatic start(input int len);
    @(posedge clock);
    #1 host_low = 1'b1;
    repeat (len) @(posedge clock);
    #1 host_low = 1'b0;
  endtask

  task automatic no_resp(input int len);
    int lows = 0, busys = 0;
    @(posedge clock);
    #1 host_low = 1'b1;
    repeat (len) begin
      @(negedge clock);
      busys += (busy === 1'b1) ? 1 : 0;
      @(posedge clock);
    end
    #1 host_low = 1'b0;
    repeat (300) begin
      @(negedge clock);
      busys += (busy === 1'b1) ? 1 : 0;
      lows  += (dat === 1'b0) ? 1 : 0;
    end
    check($sformatf("short%0d_drive", len), lows, 0);
    check($sformatf("short%0d_busy", len), busys, 0);
  endtask

  // Model: checksum is the byte sum wrapped to 0..255, complemented when corrupted;
  // each bit is a 50-cycle low then 70 (one) or 26 (zero) high, MSB first.
  task automatic frame(input logic [31:0] data, input logic inj, input int low_len,
                       input int chg_bit, input int rst_bit);
    int s, len, fd0;
    logic [39:0] exp_f, got;
    s = (int'(data[31:24]) + int'(data[23:16]) + int'(data[15:8]) + int'(data[7:0])) % 256;
    if (inj) s = 255 - s;
    exp_f = {data, 8'(s)};
    got = '0;
    {hum_int, hum_dec, tmp_int, tmp_dec} = data;
    inject_error = inj;
    start(low_len);
    fd0 = fd_cnt;
    @(negedge clock);
    cur = dat;
    get_run(len); check("turn", len, 30);
    check("busy_resp", busy, 1);
    get_run(len); check("resp_low", len, 80);
    get_run(len); check("resp_high", len, 80);
    for (int i = 0; i < 40; i++) begin
      if (i == rst_bit) begin
        check("pre_rst_low", dat, 0);
        rst_n = 1'b0;
        #1;
        check("rst_release", dat, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        return;
      end
      if (i == chg_bit) begin
        {hum_int, hum_dec, tmp_int, tmp_dec} = '0;
        inject_error = ~inj;
      end
      get_run(len); check($sformatf("bit%0d_low", i), len, 50);
      get_run(len); check($sformatf("bit%0d_high", i), len, exp_f[39-i] ? 70 : 26);
      got[39-i] = len > 48;
    end
    get_run(len); check("end_low", len, 50);
    check("rx_hum_int", got[39:32], exp_f[39:32]);
    check("rx_hum_dec", got[31:24], exp_f[31:24]);
    check("rx_tmp_int", got[23:16], exp_f[23:16]);
    check("rx_tmp_dec", got[15:8], exp_f[15:8]);
    check("rx_checksum", got[7:0], s);
    repeat (3) @(negedge clock);
    check("done_pulse", fd_cnt - fd0, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #95_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_dat", dat, 1);
    check("rst_busy0", busy, 0);
    check("rst_done0", frame_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);
    frame(32'h37001905, 1'b0, MIN, 5, -1);
    no_resp(500);
    no_resp(MIN - 1);
    frame(32'h37001905, 1'b1, MIN + int'($urandom_range(0, 20)), -1, -1);
    frame($urandom, 1'($urandom_range(0, 1)), MIN + int'($urandom_range(0, 40)), -1, 12);
    frame(32'hFFFF0102, 1'b0, MIN, -1, -1);
    repeat (2) frame($urandom, 1'($urandom_range(0, 1)), MIN + int'($urandom_range(0, 60)), -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
